// File: rtl/seq_mult_ctl_if.sv
// Handshake/status bundle between a sequential multiplier controller and
// its requester/datapath.
// The controller connects through the slave modport. The requester/datapath
// side connects through the master modport.
interface seq_mult_ctl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic             abort;
  logic             mplier_zero;
  logic             one_shot;
  logic             first;
  logic             shift_en;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             ready;

  modport master (
    output start, abort, mplier_zero,
    input  one_shot, first, shift_en, count, busy, done, ready
  );

  modport slave (
    input  start, abort, mplier_zero,
    output one_shot, first, shift_en, count, busy, done, ready
  );
endinterface

// File: rtl/seq_mult_ctl.sv
// Control FSM for a shift-and-add multiplier: IDLE -> LOAD -> RUN -> DONE.
// A rising edge on start (registered into one_shot) launches one operation.
// LOAD strobes the operand load. RUN enables one add/shift per cycle for
// WIDTH cycles. DONE pulses once.
// abort returns to IDLE from any state and leaves count untouched.
// reset overrides everything.
// Optional feature macro: SEQ_MULT_CTL_EARLY_TERM_EN. When it is defined, RUN
// ends early once the datapath reports that the remaining multiplier bits are
// zero.
module seq_mult_ctl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  seq_mult_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Moore output vector, bit order {first, shift_en, busy, done, ready}.
  typedef logic [4:0] outs_t;

  function automatic outs_t moore_outs(input state_t s);
    case (s)
      S_IDLE:  moore_outs = 5'b00001;
      S_LOAD:  moore_outs = 5'b10100;
      S_RUN:   moore_outs = 5'b01100;
      S_DONE:  moore_outs = 5'b00010;
      default: moore_outs = 5'b00000;
    endcase
  endfunction

  state_t           r_state;
  logic             r_start_q;
  logic             r_one_shot;
  logic [CNT_W-1:0] r_count;
  outs_t            r_outs;
  logic             w_last_iter;

  // Last RUN cycle: the final iteration, or (optionally) nothing left to add.
`ifdef SEQ_MULT_CTL_EARLY_TERM_EN
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1)) || bus.mplier_zero;
`else
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1));
  // The port is kept in this build, but its value is deliberately unused.
  logic w_unused_mplier_zero;
  assign w_unused_mplier_zero = bus.mplier_zero;
`endif

  // Start edge detector: one_shot pulses for one cycle per rising edge of start.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values. Blocking assignments would make the result
    // depend on statement order.
    if (reset) begin
      r_start_q  <= 1'b0;
      r_one_shot <= 1'b0;
    end else begin
      r_start_q  <= bus.start;
      r_one_shot <= bus.start & ~r_start_q;
    end
  end

  // Control FSM with its registered Moore outputs and the iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_outs  <= moore_outs(S_IDLE);
    end else if (bus.abort) begin
      // Cancel without a done pulse; count keeps the progress made so far.
      r_state <= S_IDLE;
      r_outs  <= moore_outs(S_IDLE);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_one_shot) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_outs  <= moore_outs(S_LOAD);
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
          r_outs  <= moore_outs(S_RUN);
        end
        S_RUN: begin
          r_count <= r_count + CNT_W'(1);
          if (w_last_iter) begin
            r_state <= S_DONE;
            r_outs  <= moore_outs(S_DONE);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_outs  <= moore_outs(S_IDLE);
        end
        default: begin
          r_state <= S_IDLE;
          r_outs  <= moore_outs(S_IDLE);
        end
      endcase
    end
  end

  assign bus.one_shot = r_one_shot;
  assign bus.first    = r_outs[4];
  assign bus.shift_en = r_outs[3];
  assign bus.busy     = r_outs[2];
  assign bus.done     = r_outs[1];
  assign bus.ready    = r_outs[0];
  assign bus.count    = r_count;

endmodule

// File: tb/tb_seq_mult_ctl.sv
// Directed bench for seq_mult_ctl.
// Instance u_a uses WIDTH=8 and instance u_b uses WIDTH=1.
// Each time an operation is launched, the expected final count is queued.
// The queued value is compared when done is seen.
module tb_seq_mult_ctl;

`ifdef SEQ_MULT_CTL_EARLY_TERM_EN
  localparam int EARLY_EXP = 3;
`else
  localparam int EARLY_EXP = 8;
`endif

  logic clk = 1'b0;
  logic a_reset;
  logic b_reset;

  seq_mult_ctl_if #(.WIDTH(8)) a_bus ();
  seq_mult_ctl_if #(.WIDTH(1)) b_bus ();

  seq_mult_ctl #(.WIDTH(8)) u_a (.clk(clk), .reset(a_reset), .bus(a_bus.slave));
  seq_mult_ctl #(.WIDTH(1)) u_b (.clk(clk), .reset(b_reset), .bus(b_bus.slave));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int qa[$];

  // Per-scenario observations taken by the monitor.
  int cyc = 0;
  int n_os, n_first, n_shift, n_done, c_os, c_first, c_done;
  int nb_shift = 0;
  int nb_done  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_os = 0; n_first = 0; n_shift = 0; n_done = 0;
    c_os = -1; c_first = -1; c_done = -1;
  endtask

  // Drive point: 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until u_a is in RUN with the given count; a timeout is a failure.
  task automatic wait_a_count(input int v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (a_bus.shift_en === 1'b1 && a_bus.count === 4'(v)) hit = 1'b1;
      else tick();
    end
    check("a_wait_count", 64'(hit), 64'd1);
  endtask

  task automatic check_a_idle(input string tag, input int exp_count);
    check({tag, "_ready"},    64'(a_bus.ready),    64'd1);
    check({tag, "_busy"},     64'(a_bus.busy),     64'd0);
    check({tag, "_first"},    64'(a_bus.first),    64'd0);
    check({tag, "_shift_en"}, 64'(a_bus.shift_en), 64'd0);
    check({tag, "_done"},     64'(a_bus.done),     64'd0);
    check({tag, "_count"},    64'(a_bus.count),    64'(exp_count));
  endtask

  // Monitor on the falling edge: exclusivity, count bound, event capture,
  // and scoreboard comparison at done.
  always @(negedge clk) begin
    cyc++;
    if (a_reset === 1'b0) begin
      check("a_exclusive", 64'($countones({a_bus.first, a_bus.shift_en, a_bus.done, a_bus.ready}) == 1), 64'd1);
      check("a_count_max", 64'(a_bus.count <= 4'd8), 64'd1);
      if (a_bus.one_shot === 1'b1) begin n_os++; if (c_os < 0) c_os = cyc; end
      if (a_bus.first === 1'b1)    begin n_first++; c_first = cyc; end
      if (a_bus.shift_en === 1'b1) n_shift++;
      if (a_bus.done === 1'b1) begin
        n_done++;
        c_done = cyc;
        check("a_done_expected", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) check("a_done_count", 64'(a_bus.count), 64'(qa.pop_front()));
      end
    end
    if (b_reset === 1'b0) begin
      check("b_exclusive", 64'($countones({b_bus.first, b_bus.shift_en, b_bus.done, b_bus.ready}) == 1), 64'd1);
      if (b_bus.shift_en === 1'b1) nb_shift++;
      if (b_bus.done === 1'b1)     nb_done++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_bus.start = 1'b0; a_bus.abort = 1'b0; a_bus.mplier_zero = 1'b0;
    b_bus.start = 1'b0; b_bus.abort = 1'b0; b_bus.mplier_zero = 1'b0;
    clear_stats();

    // Reset for two cycles, then release.
    tick(); tick();
    check_a_idle("rst_hold", 0);
    check("rst_hold_one_shot", 64'(a_bus.one_shot), 64'd0);
    a_reset = 1'b0;
    tick();
    check_a_idle("rst_rel", 0);
    check("rst_rel_one_shot", 64'(a_bus.one_shot), 64'd0);

    // Basic multiply: start held high for 20 cycles.
    clear_stats();
    qa.push_back(8);
    a_bus.start = 1'b1;
    tick();
    check("basic_one_shot", 64'(a_bus.one_shot), 64'd1);
    tick();
    check("basic_first", 64'(a_bus.first), 64'd1);
    check("basic_load_busy", 64'(a_bus.busy), 64'd1);
    check("basic_load_count", 64'(a_bus.count), 64'd0);
    repeat (18) tick();
    a_bus.start = 1'b0;
    tick();
    check("basic_n_one_shot", 64'(n_os), 64'd1);
    check("basic_first_lat", 64'(c_first - c_os), 64'd1);
    check("basic_n_shift", 64'(n_shift), 64'd8);
    check("basic_done_lat", 64'(c_done - c_first), 64'd9);
    check("basic_n_done", 64'(n_done), 64'd1);
    check_a_idle("basic_end", 8);

    // Restart while busy: a second start edge three cycles into RUN.
    clear_stats();
    qa.push_back(8);
    a_bus.start = 1'b1;
    tick();
    a_bus.start = 1'b0;
    repeat (4) tick();
    check("restart_count", 64'(a_bus.count), 64'd2);
    check("restart_shift_en", 64'(a_bus.shift_en), 64'd1);
    a_bus.start = 1'b1;
    tick();
    check("restart_one_shot", 64'(a_bus.one_shot), 64'd1);
    a_bus.start = 1'b0;
    repeat (12) tick();
    check("restart_n_one_shot", 64'(n_os), 64'd2);
    check("restart_n_first", 64'(n_first), 64'd1);
    check("restart_n_done", 64'(n_done), 64'd1);
    check_a_idle("restart_end", 8);

    // Abort at count=4: back to IDLE, no done, count held.
    clear_stats();
    a_bus.start = 1'b1;
    tick();
    a_bus.start = 1'b0;
    wait_a_count(4);
    a_bus.abort = 1'b1;
    tick();
    a_bus.abort = 1'b0;
    check_a_idle("abort", 4);
    repeat (3) tick();
    check("abort_n_done", 64'(n_done), 64'd0);
    check_a_idle("abort_after", 4);

    // abort and one_shot in the same IDLE cycle: abort wins, nothing queued.
    clear_stats();
    a_bus.abort = 1'b1;
    a_bus.start = 1'b1;
    tick();
    check("abort_os_pulse", 64'(a_bus.one_shot), 64'd1);
    tick();
    a_bus.abort = 1'b0;
    a_bus.start = 1'b0;
    check_a_idle("abort_os", 4);
    repeat (2) tick();
    check("abort_os_n_first", 64'(n_first), 64'd0);

    // Reset at count=5 overrides abort/start; start held through release.
    a_bus.start = 1'b1;
    tick();
    a_bus.start = 1'b0;
    wait_a_count(5);
    a_reset = 1'b1;
    a_bus.start = 1'b1;
    a_bus.abort = 1'b1;
    tick();
    check_a_idle("midrst", 0);
    check("midrst_one_shot", 64'(a_bus.one_shot), 64'd0);
    tick();
    a_bus.abort = 1'b0;
    qa.push_back(8);
    a_reset = 1'b0;
    tick();
    check("midrst_rel_one_shot", 64'(a_bus.one_shot), 64'd1);
    repeat (12) tick();
    a_bus.start = 1'b0;
    tick();
    check_a_idle("midrst_end", 8);

    // Early termination request at count=2.
    clear_stats();
    qa.push_back(EARLY_EXP);
    a_bus.start = 1'b1;
    tick();
    a_bus.start = 1'b0;
    wait_a_count(2);
    a_bus.mplier_zero = 1'b1;
    tick();
    a_bus.mplier_zero = 1'b0;
    check("early_count", 64'(a_bus.count), 64'd3);
`ifdef SEQ_MULT_CTL_EARLY_TERM_EN
    check("early_done", 64'(a_bus.done), 64'd1);
`else
    check("early_shift_en", 64'(a_bus.shift_en), 64'd1);
`endif
    repeat (10) tick();
    check("early_n_shift", 64'(n_shift), 64'(EARLY_EXP));
    check_a_idle("early_end", EARLY_EXP);

    // WIDTH=1 instance.
    b_reset = 1'b0;
    tick();
    check("b_rst_ready", 64'(b_bus.ready), 64'd1);
    check("b_rst_count", 64'(b_bus.count), 64'd0);
    b_bus.start = 1'b1;
    tick();
    check("b_one_shot", 64'(b_bus.one_shot), 64'd1);
    tick();
    check("b_first", 64'(b_bus.first), 64'd1);
    tick();
    check("b_shift_en", 64'(b_bus.shift_en), 64'd1);
    check("b_run_count", 64'(b_bus.count), 64'd0);
    tick();
    check("b_done", 64'(b_bus.done), 64'd1);
    check("b_done_count", 64'(b_bus.count), 64'd1);
    tick();
    b_bus.start = 1'b0;
    check("b_ready", 64'(b_bus.ready), 64'd1);
    check("b_n_shift", 64'(nb_shift), 64'd1);
    check("b_n_done", 64'(nb_done), 64'd1);

    check("a_scoreboard_empty", 64'(qa.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctl.md
SEQ_MULT_CTL -- requirements
Module: seq_mult_ctl

Interface
REQ-001 Parameter WIDTH, default 16, number of multiplier iterations (operand width); legal range 1..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the iteration counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port start  input  1  level request; a rising edge starts one multiplication.
REQ-006 Port abort  input  1  synchronous cancel of the operation in progress.
REQ-007 Port mplier_zero  input  1  datapath flag: remaining multiplier bits are all zero.
REQ-008 Port one_shot  output  1  registered single-cycle pulse on each start rising edge.
REQ-009 Port first  output  1  load strobe: datapath loads operands and clears the accumulator.
REQ-010 Port shift_en  output  1  datapath add/shift enable, one iteration per cycle.
REQ-011 Port count  output  CNT_W  number of completed iterations.
REQ-012 Port busy  output  1  high in LOAD and RUN.
REQ-013 Port done  output  1  single-cycle pulse: product valid.
REQ-014 Port ready  output  1  high in IDLE: a new start is accepted.

Function
REQ-015 The block SHALL register start into start_q every cycle and SHALL drive one_shot=1 for exactly one cycle after an edge that samples start=1 with start_q=0.
REQ-016 start held high for any number of cycles SHALL produce exactly one one_shot pulse.
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, with Moore outputs only.
REQ-018 IDLE: ready=1. IDLE SHALL go to LOAD on an edge where one_shot=1.
REQ-019 LOAD: first=1 and busy=1 for exactly one cycle, count cleared to 0. LOAD SHALL always go to RUN.
REQ-020 RUN: shift_en=1 and busy=1. count SHALL increment on every RUN edge.
REQ-021 RUN SHALL go to DONE on the edge where count goes from WIDTH-1 to WIDTH. Exactly WIDTH shift_en cycles SHALL occur.
REQ-022 DONE: done=1 for one cycle, and count SHALL hold its final value. DONE SHALL always go to IDLE.
REQ-023 Latency: first SHALL be high 1 cycle after one_shot, and done SHALL be high WIDTH+1 cycles after first.
REQ-024 A one_shot in LOAD, RUN or DONE SHALL be ignored by the FSM; it SHALL NOT queue a start.
REQ-025 abort=1 SHALL force IDLE on the next edge from any state, with no done pulse. count SHALL hold its value.
REQ-026 abort and one_shot in the same IDLE cycle: abort SHALL win and the state SHALL stay IDLE.
REQ-027 With WIDTH=1: RUN SHALL last one cycle and count SHALL end at 1.
REQ-028 count SHALL NOT exceed WIDTH.
REQ-029 first, shift_en, done and ready SHALL be mutually exclusive in every cycle.

Reset
REQ-030 reset=1 SHALL take priority over abort and start, in every state including mid-RUN.
REQ-031 After a reset edge: state=IDLE, start_q=0, one_shot=0, first=0, shift_en=0, count=0, busy=0, done=0, ready=1.
REQ-032 start held high through the deassertion of reset SHALL produce a one_shot on the first edge after reset is released, because start_q was cleared to 0.

Configuration
REQ-033 Macro SEQ_MULT_CTL_EARLY_TERM_EN.
- Defined: in RUN, an edge with mplier_zero=1 SHALL go to DONE with count incremented as normal.
- Defined: this gives fewer than WIDTH shift_en cycles.
- Undefined: mplier_zero SHALL be ignored. The port SHALL remain present and every run SHALL take exactly WIDTH iterations.

Verification (WIDTH=8 unless stated)
REQ-034 Reset sequence: reset=1 for 2 cycles, then 0 -> ready=1, count=0, all other outputs 0.
REQ-035 Basic multiply: start 0->1, held 20 cycles ->
- exactly one one_shot pulse;
- first 1 cycle later;
- shift_en for 8 cycles;
- done 9 cycles after first;
- count=8, then ready=1.
REQ-036 Restart while busy: a second start edge 3 cycles into RUN -> one_shot pulses, no second first, single done.
REQ-037 Abort and reset mid-operation:
- abort=1 at count=4 -> IDLE next cycle, no done, count=4;
- reset=1 at count=5 -> IDLE, count=0.
REQ-038 Early termination: mplier_zero=1 at count=2 ->
- with SEQ_MULT_CTL_EARLY_TERM_EN defined: DONE next edge, count=3;
- with it undefined: count=8.
REQ-039 Minimum width: WIDTH=1, one start -> exactly one shift_en cycle, count=1, done 2 cycles after first.
